pipe_ctrl_hazard: RTL

PIPE_CTRL_HAZARD -- requirements
Module: pipe_ctrl_hazard

---
 rtl/pipe_ctrl_hazard.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_hazard.sv
// Pipeline controller for a 5-stage MIPS-style core: decodes control in D and carries it to E/M/W.
// Latency: hazard/forward/branch outputs are combinational; stage controls appear 1/2/3 cycles after decode.
// Backpressure: load-use and branch-operand hazards stall F/D and inject a bubble into E.
module pipe_ctrl_hazard #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic              branch_boolean,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        RsE,
    input  logic [4:0]        RtE,
    input  logic [ADDR_W-1:0] WriteRegE,
    input  logic [ADDR_W-1:0] WriteRegM,
    input  logic [ADDR_W-1:0] WriteRegW,
    output logic              PCSrc,
    output logic              JumpC,
    output logic              RegDstE,
    output logic              ALUSrcB,
    output logic [2:0]        ALUControlE,
    output logic              MemWrite,
    output logic              MemToReg,
    output logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
);

    logic       w_regwrite_d;
    logic       w_memtoreg_d;
    logic       w_memwrite_d;
    logic       w_alusrc_d;
    logic       w_regdst_d;
    logic       w_branch_d;
    logic       w_jump_d;
    logic [1:0] w_aluop_d;
    logic [2:0] w_aluctrl_d;

    logic       r_regwrite_e;
    logic       r_memtoreg_e;
    logic       r_memwrite_e;
    logic       r_alusrc_e;
    logic       r_regdst_e;
    logic [2:0] r_aluctrl_e;
    logic       r_regwrite_m;
    logic       r_memtoreg_m;
    logic       r_memwrite_m;
    logic       r_regwrite_w;
    logic       r_memtoreg_w;

    logic [4:0] w_wreg_e;
    logic [4:0] w_wreg_m;
    logic [4:0] w_wreg_w;
    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_stall;

    always_comb begin
        w_regwrite_d = 1'b0;
        w_memtoreg_d = 1'b0;
        w_memwrite_d = 1'b0;
        w_alusrc_d   = 1'b0;
        w_regdst_d   = 1'b0;
        w_branch_d   = 1'b0;
        w_jump_d     = 1'b0;
        w_aluop_d    = 2'b00;
        case (Opcode)
            6'b000000: begin w_regwrite_d = 1'b1; w_regdst_d = 1'b1; w_aluop_d = 2'b10; end
            6'b100011: begin w_regwrite_d = 1'b1; w_alusrc_d = 1'b1; w_memtoreg_d = 1'b1; end
            6'b101011: begin w_alusrc_d = 1'b1; w_memwrite_d = 1'b1; end
            6'b000100: begin w_branch_d = 1'b1; w_aluop_d = 2'b01; end
            6'b001000: begin w_regwrite_d = 1'b1; w_alusrc_d = 1'b1; end
            6'b000010: w_jump_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_aluctrl_d = 3'b010;
        case (w_aluop_d)
            2'b01: w_aluctrl_d = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100010: w_aluctrl_d = 3'b110;
                    6'b100100: w_aluctrl_d = 3'b000;
                    6'b100101: w_aluctrl_d = 3'b001;
                    6'b101010: w_aluctrl_d = 3'b111;
                    default:   w_aluctrl_d = 3'b010;
                endcase
            end
            default: w_aluctrl_d = 3'b010;
        endcase
    end

    // A stalled instruction stays in D, so E receives a bubble instead of a copy.
    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_aluctrl_e  <= 3'b000;
        end else begin
            r_regwrite_e <= w_regwrite_d;
            r_memtoreg_e <= w_memtoreg_d;
            r_memwrite_e <= w_memwrite_d;
            r_alusrc_e   <= w_alusrc_d;
            r_regdst_e   <= w_regdst_d;
            r_aluctrl_e  <= w_aluctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_memwrite_m <= r_memwrite_e;
            r_regwrite_w <= r_regwrite_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

    assign w_wreg_e = WriteRegE[4:0];
    assign w_wreg_m = WriteRegM[4:0];
    assign w_wreg_w = WriteRegW[4:0];

    assign w_lwstall = r_memtoreg_e && ((A1 == RtE) || (A2 == RtE));

    // Writes to register 0 are architecturally discarded, so they never create a dependency.
    assign w_branchstall = w_branch_d &&
        ((r_regwrite_e && (w_wreg_e != 5'd0) && ((w_wreg_e == A1) || (w_wreg_e == A2))) ||
         (r_memtoreg_m && (w_wreg_m != 5'd0) && ((w_wreg_m == A1) || (w_wreg_m == A2))));

    assign w_stall = w_lwstall || w_branchstall;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;
    assign PCSrc  = w_branch_d && branch_boolean && !w_stall;
    assign JumpC  = w_jump_d;

    assign ForwardAD = (A1 != 5'd0) && r_regwrite_m && (A1 == w_wreg_m);
    assign ForwardBD = (A2 != 5'd0) && r_regwrite_m && (A2 == w_wreg_m);

    always_comb begin
        ForwardAE = 2'b00;
        if ((RsE != 5'd0) && r_regwrite_m && (RsE == w_wreg_m))
            ForwardAE = 2'b10;
        else if ((RsE != 5'd0) && r_regwrite_w && (RsE == w_wreg_w))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if ((RtE != 5'd0) && r_regwrite_m && (RtE == w_wreg_m))
            ForwardBE = 2'b10;
        else if ((RtE != 5'd0) && r_regwrite_w && (RtE == w_wreg_w))
            ForwardBE = 2'b01;
    end

    assign RegDstE     = r_regdst_e;
    assign ALUSrcB     = r_alusrc_e;
    assign ALUControlE = r_aluctrl_e;
    assign MemWrite    = r_memwrite_m;
    assign MemToReg    = r_memtoreg_w;
    assign RegWriteW   = r_regwrite_w;

endmodule
